// File: rtl/axis_sync_fifo.sv
// AXI4-Stream synchronous FIFO, first-word-fall-through with registered outputs.
// Optional store-and-forward packet mode: define AXIS_SYNC_FIFO_PKT_MODE_EN.
module axis_sync_fifo #(
    parameter int DW    = 8,
    parameter int UW    = 1,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DW-1:0]            s_tdata,
    input  logic [UW-1:0]            s_tuser,
    input  logic                     s_tlast,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DW-1:0]            m_tdata,
    output logic [UW-1:0]            m_tuser,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = DW + UW + 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Stored word layout: {tdata, tuser, tlast}
    logic [WW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [AW:0]   remain;
    logic          s_tready_reg;
    logic          s_tready_next;
    logic          m_tvalid_reg;
    logic          m_tvalid_next;
    logic [WW-1:0] m_word_reg;
    logic [WW-1:0] s_word;
    logic          wr_en;
    logic          rd_en;
    logic          bypass;

    always_comb begin
        s_word      = {s_tdata, s_tuser, s_tlast};
        wr_en       = s_tvalid && s_tready_reg;
        rd_en       = m_tvalid_reg && m_tready;
        wr_ptr_next = wr_ptr_reg + AW'(wr_en);
        rd_ptr_next = rd_ptr_reg + AW'(rd_en);
        remain      = count_reg - (AW+1)'(rd_en);
        count_next  = remain + (AW+1)'(wr_en);
        // The word being written becomes the head when nothing older remains.
        bypass        = wr_en && (remain == '0);
        s_tready_next = (count_next < DEPTH_C);
    end

`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
    logic [AW:0] pkt_cnt_reg;
    logic [AW:0] pkt_cnt_next;

    always_comb begin
        pkt_cnt_next = pkt_cnt_reg
                     - (AW+1)'(rd_en && m_word_reg[0])
                     + (AW+1)'(wr_en && s_tlast);
        // Releasing a full FIFO lets oversized packets drain word by word.
        m_tvalid_next = (count_next != '0) &&
                        ((pkt_cnt_next != '0) || (count_next == DEPTH_C));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_cnt_reg <= '0;
        end else begin
            pkt_cnt_reg <= pkt_cnt_next;
        end
    end
`else
    always_comb begin
        m_tvalid_next = (count_next != '0);
    end
`endif

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= s_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            s_tready_reg <= 1'b0;
            m_tvalid_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            s_tready_reg <= s_tready_next;
            m_tvalid_reg <= m_tvalid_next;
        end
    end

    // Head register holds the word at the next read pointer, zero when invalid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_word_reg <= '0;
        end else if (!m_tvalid_next) begin
            m_word_reg <= '0;
        end else if (bypass) begin
            m_word_reg <= s_word;
        end else begin
            m_word_reg <= mem[rd_ptr_next];
        end
    end

    assign s_tready = s_tready_reg;
    assign m_tvalid = m_tvalid_reg;
    assign m_tdata  = m_word_reg[WW-1 -: DW];
    assign m_tuser  = m_word_reg[UW:1];
    assign m_tlast  = m_word_reg[0];
    assign count    = count_reg;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Self-checking bench for axis_sync_fifo (DW=8, UW=1, DEPTH=4) against a queue model.
module tb_axis_sync_fifo;

    localparam int DW    = 8;
    localparam int UW    = 1;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef logic [DW+UW:0] word_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] s_tdata;
    logic [UW-1:0] s_tuser;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    axis_sync_fifo #(.DW(DW), .UW(UW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_tdata  (s_tdata),
        .s_tuser  (s_tuser),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .count    (count)
    );

    word_t q[$];
    bit    mdl_ready;
    int    n_checks;
    int    n_fail;

    function automatic bit mdl_valid();
`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
        bit has_last = 1'b0;
        foreach (q[i]) if (q[i][0]) has_last = 1'b1;
        return (q.size() > 0) && (has_last || q.size() == DEPTH);
`else
        return q.size() > 0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_data();
        word_t w;
        if (!mdl_valid()) return '0;
        w = q[0];
        return w[DW+UW:UW+1];
    endfunction

    function automatic logic [UW-1:0] exp_user();
        word_t w;
        if (!mdl_valid()) return '0;
        w = q[0];
        return w[UW:1];
    endfunction

    function automatic logic exp_last();
        word_t w;
        if (!mdl_valid()) return 1'b0;
        w = q[0];
        return w[0];
    endfunction

    // One clock edge; the model applies the handshakes it predicts for this edge.
    task automatic tick();
        bit    wr;
        bit    rd;
        word_t w;
        wr = rstn && s_tvalid && mdl_ready;
        rd = rstn && mdl_valid() && m_tready;
        w  = {s_tdata, s_tuser, s_tlast};
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            mdl_ready = 1'b0;
        end else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(w);
            mdl_ready = (q.size() < DEPTH);
        end
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
        s_tdata = 8'h5A; s_tuser = 1'b1; s_tlast = 1'b1;
        tick(); tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
        n_checks++; if ({m_tdata, m_tuser, m_tlast} !== '0) begin n_fail++; $display("FAIL reset_m_word got=%h exp=0", {m_tdata, m_tuser, m_tlast}); end
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
        rstn = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
        tick();
        n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_s_tready got=%b exp=1", s_tready); end
        $display("test_reset done");
    endtask

    task automatic test_hold();
        do_reset();
        m_tready = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        s_tvalid = 1'b1; s_tdata = 8'h11; tick();
        s_tdata = 8'h22; tick();
        s_tvalid = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL hold_count got=%0d exp=2", count); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h11) begin n_fail++; $display("FAIL hold_stable cyc=%0d got v=%b d=%h exp v=1 d=11", i, m_tvalid, m_tdata); end
            s_tdata = 8'($urandom);
            tick();
        end
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL hold_no_effect_count got=%0d exp=2", count); end
        $display("test_hold done");
    endtask

    task automatic test_full();
        do_reset();
        m_tready = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tdata = 8'hA0 + 8'(i);
            tick();
        end
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL full_s_tready got=%b exp=0", s_tready); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
        s_tdata = 8'hEE; m_tready = 1'b1;
        n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hA0) begin n_fail++; $display("FAIL full_head got v=%b d=%h exp v=1 d=a0", m_tvalid, m_tdata); end
        tick();
        s_tvalid = 1'b0; m_tready = 1'b0;
        n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got=%b exp=1", s_tready); end
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_no_write_count got=%0d exp=3", count); end
        m_tready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (m_tdata !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL full_drain i=%0d got=%h exp=%h", i, m_tdata, 8'hA0 + 8'(i)); end
            tick();
        end
        m_tready = 1'b0;
        n_checks++; if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || count !== 3'd0) begin n_fail++; $display("FAIL full_empty got v=%b d=%h c=%0d exp v=0 d=00 c=0", m_tvalid, m_tdata, count); end
        $display("test_full done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] nxt;
        logic [7:0] exp_out;
        do_reset();
        m_tready = 1'b0; s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
        s_tdata = 8'h30; tick();
        s_tdata = 8'h31; tick();
        nxt = 8'h32; exp_out = 8'h30;
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_tdata = nxt;
            n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== exp_out) begin n_fail++; $display("FAIL b2b_out cyc=%0d got v=%b d=%h exp v=1 d=%h", i, m_tvalid, m_tdata, exp_out); end
            tick();
            nxt++; exp_out++;
            n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count cyc=%0d got=%0d exp=2", i, count); end
        end
        s_tvalid = 1'b0; m_tready = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_stream();
        word_t sent[6];
        int    idx = 0;
        int    got = 0;
        do_reset();
        for (int i = 0; i < 6; i++) sent[i] = {8'(i + 1), 1'($urandom), 1'($urandom)};
        for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
            s_tvalid = (idx < 6) && ($urandom_range(0, 1) == 1);
            {s_tdata, s_tuser, s_tlast} = (idx < 6) ? sent[idx] : '0;
            m_tready = ($urandom_range(0, 1) == 1);
            if (m_tvalid && m_tready) begin
                n_checks++;
                if (got >= 6) begin
                    n_fail++; $display("FAIL stream_extra got=%h exp=none", {m_tdata, m_tuser, m_tlast});
                end else if ({m_tdata, m_tuser, m_tlast} !== sent[got]) begin
                    n_fail++; $display("FAIL stream_order n=%0d got=%h exp=%h", got, {m_tdata, m_tuser, m_tlast}, sent[got]);
                end
                got++;
            end
            if (s_tvalid && mdl_ready) idx++;
            tick();
            n_checks++; if (count !== (AW+1)'(q.size())) begin n_fail++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", cyc, count, q.size()); end
        end
        s_tvalid = 1'b0; m_tready = 1'b0;
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL stream_received got=%0d exp=6", got); end
        $display("test_stream done words=%0d", got);
    endtask

    task automatic test_mid_reset();
        do_reset();
        m_tready = 1'b0; s_tuser = 1'b1; s_tlast = 1'b1; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 8'hC0 + 8'(i);
            tick();
        end
        s_tvalid = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL midrst_pre_count got=%0d exp=3", count); end
        rstn = 1'b0; tick();
        n_checks++; if (count !== 3'd0 || m_tvalid !== 1'b0 || m_tdata !== 8'h00 || s_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_state got c=%0d v=%b d=%h r=%b exp c=0 v=0 d=00 r=0", count, m_tvalid, m_tdata, s_tready); end
        rstn = 1'b1; tick();
        n_checks++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || m_tdata !== 8'h00 || count !== 3'd0) begin n_fail++; $display("FAIL midrst_release got r=%b v=%b d=%h c=%0d exp r=1 v=0 d=00 c=0", s_tready, m_tvalid, m_tdata, count); end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        int rp;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rp = (cyc / 50) % 4;
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = 8'($urandom);
            s_tuser  = 1'($urandom);
            s_tlast  = ($urandom_range(0, 2) == 0);
            m_tready = ($urandom_range(0, 3) < rp);
            tick();
            n_checks++;
            if (count !== (AW+1)'(q.size()) || s_tready !== mdl_ready || m_tvalid !== mdl_valid()) begin
                n_fail++; $display("FAIL rand_ctrl cyc=%0d got c=%0d r=%b v=%b exp c=%0d r=%b v=%b", cyc, count, s_tready, m_tvalid, q.size(), mdl_ready, mdl_valid());
            end
            n_checks++;
            if (m_tdata !== exp_data() || m_tuser !== exp_user() || m_tlast !== exp_last()) begin
                n_fail++; $display("FAIL rand_word cyc=%0d got=%h/%b/%b exp=%h/%b/%b", cyc, m_tdata, m_tuser, m_tlast, exp_data(), exp_user(), exp_last());
            end
        end
        s_tvalid = 1'b0; m_tready = 1'b0;
        $display("test_random done");
    endtask

`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
    task automatic test_pkt_mode();
        int         k = 0;
        int         got = 0;
        int         first_cnt = -1;
        logic [7:0] exp_d;
        do_reset();
        m_tready = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 8'h50 + 8'(i); s_tlast = (i == 2);
            tick();
            n_checks++; if (m_tvalid !== (i == 2)) begin n_fail++; $display("FAIL pkt_gate i=%0d got=%b exp=%b", i, m_tvalid, (i == 2)); end
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        n_checks++; if (m_tdata !== 8'h50) begin n_fail++; $display("FAIL pkt_head got=%h exp=50", m_tdata); end
        tick(); tick(); tick();
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            s_tvalid = (k < 6);
            s_tdata = 8'h60 + 8'(k); s_tlast = (k == 5);
            m_tready = 1'b1;
            if (m_tvalid) begin
                if (first_cnt < 0) first_cnt = int'(count);
                exp_d = 8'h60 + 8'(got);
                n_checks++; if (m_tdata !== exp_d) begin n_fail++; $display("FAIL pkt_long_order n=%0d got=%h exp=%h", got, m_tdata, exp_d); end
                got++;
            end
            if (s_tvalid && mdl_ready) k++;
            tick();
        end
        s_tvalid = 1'b0; m_tready = 1'b0;
        n_checks++; if (first_cnt != DEPTH) begin n_fail++; $display("FAIL pkt_long_release got=%0d exp=%0d", first_cnt, DEPTH); end
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL pkt_long_received got=%0d exp=6", got); end
        $display("test_pkt_mode done");
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0; mdl_ready = 1'b0;
        rstn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        s_tdata = '0; s_tuser = '0; s_tlast = 1'b0;
        test_reset();
`ifdef AXIS_SYNC_FIFO_PKT_MODE_EN
        test_pkt_mode();
        test_mid_reset();
`else
        test_hold();
        test_full();
        test_back_to_back();
        test_stream();
        test_mid_reset();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
